kv10_mem_responder: RTL and testbench
=====================================

# kv10_mem_responder

Memory responder for the KV10 memory bus: the slave end of the processor's memory interface. Accepts one read or write request at a time from the bus initiator, services it from an internal word-addressed RAM after a programmable number of wait states, and answers with a one-cycle acknowledge or page-fail pulse. It sits between the processor's memory port and on-chip backing store, and also serves as the reference responder for bus-initiator verification.

## Interface
- `MEM_WORDS`, 4096: implemented words. Addresses at or above this page-fail.
- `LATENCY`, 2: wait-state cycles before acknowledge. Legal range 1..15.
- `clk`  in  1: single clock. All activity is on the rising edge.
- `reset`  in  1: synchronous, active-low. It is also the membus `reset`.
- `address`  in  `` `ADDR `` (18): word address from the initiator.
- `write_data`  in  `` `WORD `` (36): store data.
- `read`  in  1: read request level.
- `write`  in  1: write request level.
- `read_data`  out  `` `WORD ``: load data. Valid in the `read_ack` cycle and held until the next read ack or reset.
- `read_ack`  out  1: one-cycle read-complete pulse.
- `write_ack`  out  1: one-cycle write-complete pulse.
- `page_fail`  out  1: one-cycle pulse that replaces the ack on a faulting request.

## Operation
- Reset (`reset`=0 at an edge) puts the block in IDLE and clears `read_data`, `read_ack`, `write_ack` and `page_fail` to 0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP, DONE.
- **IDLE**
  - When `read` or `write` is 1, latch `address`, `write_data` and the operation, load the wait counter with `LATENCY`-1, and go to WAIT.
  - Fault decode happens at latch time. The request is a fault if `address` >= `MEM_WORDS`, or if `read` and `write` are both 1.
- **WAIT**: decrement the counter. At zero, go to RESP.
  - Read, no fault: issue the RAM read on the transition edge.
  - Write, no fault: no RAM activity in WAIT.
- **RESP**: lasts one cycle. Exactly one of these holds:
  - Read, no fault: `read_ack`=1 and `read_data`=RAM word.
  - Write, no fault: `write_ack`=1, and the RAM write commits on the edge that leaves RESP.
  - Fault: `page_fail`=1, with no RAM write and `read_data` unchanged.
  - Next state is DONE.
- **DONE**: all pulses are 0. Stay in DONE until `read`=0 and `write`=0 are sampled, then go to IDLE.
- Initiator rule: hold `address`, `write_data` and the request level stable until ack or page_fail, then drop the request. Inputs are ignored outside IDLE; the block latches them, so changes after the latch edge have no effect.
- Address width: only the low clog2(`MEM_WORDS`) bits index the RAM. The fault check always uses the full 18-bit address.

## Timing
- Request first sampled high at edge E0. The ack or page_fail is high during the cycle after edge E0+`LATENCY`+1 and low after edge E0+`LATENCY`+2.
  - With `LATENCY`=2, the pulse is visible after edge E0+3.
- Back-to-back requests: request drops and is sampled low at edge Ed. The next request is sampled no earlier than edge Ed+1, so there is at least one bubble per transaction.
- Throughput limit: one transaction per `LATENCY`+3 cycles.
- The three response pulses are mutually exclusive and each lasts exactly one cycle.
- Reset mid-transaction returns to IDLE on that edge and all pulses drop.
  - A write commits only if its RESP-exit edge has already occurred.
  - A pending read produces no ack.
- Request held high through RESP and DONE: no second transaction starts.

## Structure
- Shared header `kv10.svh` holds the `addr`, `word` and `sig` typedefs and the `` `ADDR `` / `` `WORD `` macros.
- Add to the shared package: the FSM state enum `mresp_state_t` and a `MEMBUS_MAX_LATENCY` constant (15).
- Sub-module `kv10_mem_array`: single-port synchronous RAM, `MEM_WORDS` x 36.
  - One-cycle read latency.
  - Write-enable port, no reset.
  - Inferable as block RAM.

## Test plan
- **Write then read:** write 36'o123456_701234 to 0o100, then read 0o100. Expect `write_ack` after edge E0+3, then `read_ack` with `read_data`=36'o123456701234. `LATENCY`=2.
- **Out-of-range address:** read 0o10000 with `MEM_WORDS`=4096. Expect one `page_fail` pulse, no `read_ack`, and `read_data` unchanged.
- **Illegal request:** `read`=`write`=1 at 0o5. Expect `page_fail`. A following read of 0o5 returns its prior contents.
- **Held request:** keep `read` high for 10 cycles after ack. Expect exactly one `read_ack` and FSM in DONE. Drop `read`; the next request is accepted one edge later.
- **Reset mid-write:** `reset`=0 during WAIT of a write to 0o200 holding 0. Expect all outputs 0 next cycle. A later read of 0o200 returns 0.
- **Latency sweep:** `LATENCY`=1 and 15. Expect the ack after edges E0+2 and E0+16 respectively, with no pulse overlap.

Source files
------------

// File: rtl/kv10_mem_responder_pkg.sv
// Shared KV10 memory-bus types, widths and responder FSM encoding.
package kv10_mem_responder_pkg;

    localparam int unsigned ADDR_W             = 18;
    localparam int unsigned WORD_W             = 36;
    localparam int unsigned MEMBUS_MAX_LATENCY = 15;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic              sig_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        DONE
    } mresp_state_t;

    // Request as captured in IDLE; the fault is decoded once, at latch time.
    typedef struct packed {
        sig_t  rd;
        sig_t  fault;
        word_t wdata;
    } mreq_t;

endpackage

// File: rtl/kv10_mem_responder_if.sv
// KV10 memory bus: initiator drives the request, responder answers with pulses.
interface kv10_mem_responder_if;

    kv10_mem_responder_pkg::addr_t address;
    kv10_mem_responder_pkg::word_t write_data;
    logic                          read;
    logic                          write;
    kv10_mem_responder_pkg::word_t read_data;
    logic                          read_ack;
    logic                          write_ack;
    logic                          page_fail;

    modport master (
        output address, write_data, read, write,
        input  read_data, read_ack, write_ack, page_fail
    );

    modport slave (
        input  address, write_data, read, write,
        output read_data, read_ack, write_ack, page_fail
    );

endinterface

// File: rtl/kv10_mem_array.sv
// Single-port synchronous RAM with one-cycle read latency; no reset so it maps to block RAM.
module kv10_mem_array #(
    parameter int unsigned WORDS     = 4096,
    parameter int unsigned WIDTH     = 36,
    parameter int unsigned ADDR_BITS = $clog2(WORDS)
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 we,
    input  logic                 re,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [WORDS];

    // Write port and registered read port share the single address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/kv10_mem_responder.sv
// KV10 memory responder: latches one request, waits LATENCY cycles, answers with one pulse.
module kv10_mem_responder
    import kv10_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    kv10_mem_responder_if.slave  bus
);

    localparam int unsigned      AW       = $clog2(MEM_WORDS);
    localparam int unsigned      CNT_W    = $clog2(MEMBUS_MAX_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    mresp_state_t     state, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    ram_addr_q, ram_addr_d;
    mreq_t            req_q, req_d;
    word_t            read_data_q, read_data_d;
    logic             read_ack_q, read_ack_d;
    logic             write_ack_q, write_ack_d;
    logic             page_fail_q, page_fail_d;
    logic             req_fault_c;
    logic             ram_re_c;
    logic             ram_we_c;
    word_t            ram_rdata;

    // Fault decode uses the full bus address, not just the RAM index bits.
    assign req_fault_c = (32'(bus.address) >= 32'(MEM_WORDS)) || (bus.read && bus.write);

    // Next-state, request capture and next-cycle response pulses.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt_q;
        ram_addr_d  = ram_addr_q;
        req_d       = req_q;
        read_data_d = read_data_q;
        read_ack_d  = 1'b0;
        write_ack_d = 1'b0;
        page_fail_d = 1'b0;
        ram_re_c    = 1'b0;
        ram_we_c    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.read || bus.write) begin
                    ram_addr_d  = bus.address[AW-1:0];
                    req_d.rd    = bus.read;
                    req_d.fault = req_fault_c;
                    req_d.wdata = bus.write_data;
                    cnt_d       = CNT_LOAD;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    ram_re_c = req_q.rd && !req_q.fault;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = DONE;
                if (req_q.fault) begin
                    page_fail_d = 1'b1;
                end else if (req_q.rd) begin
                    read_ack_d  = 1'b1;
                    read_data_d = ram_rdata;
                end else begin
                    write_ack_d = 1'b1;
                    // A reset on the commit edge cancels the store.
                    ram_we_c    = reset;
                end
            end
            DONE: begin
                if (!bus.read && !bus.write) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Latched request, wait counter and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= '0;
            ram_addr_q  <= '0;
            req_q       <= '0;
            read_data_q <= '0;
            read_ack_q  <= 1'b0;
            write_ack_q <= 1'b0;
            page_fail_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ram_addr_q  <= ram_addr_d;
            req_q       <= req_d;
            read_data_q <= read_data_d;
            read_ack_q  <= read_ack_d;
            write_ack_q <= write_ack_d;
            page_fail_q <= page_fail_d;
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.read_ack  = read_ack_q;
    assign bus.write_ack = write_ack_q;
    assign bus.page_fail = page_fail_q;

    kv10_mem_array #(
        .WORDS     (MEM_WORDS),
        .WIDTH     (WORD_W),
        .ADDR_BITS (AW)
    ) u_array (
        .clk   (clk),
        .addr  (ram_addr_q),
        .we    (ram_we_c),
        .re    (ram_re_c),
        .wdata (req_q.wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_kv10_mem_responder.sv
// Self-checking bench: three responders (LATENCY 2, 1, 15) against a memory/response model.
module tb_kv10_mem_responder;
    import kv10_mem_responder_pkg::*;

    localparam int NDUT = 3;
    localparam int MEMW = 4096;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    addr_t            t_addr  [NDUT];
    word_t            t_wdata [NDUT];
    word_t            t_rdata [NDUT];
    logic [NDUT-1:0]  t_rd, t_wr, t_rack, t_wack, t_pf;

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents per responder and the held read_data value.
    word_t mem_m [int];
    word_t last_rd [NDUT];

    // Observations of the most recent transaction.
    int    o_lat, o_rack, o_wack, o_pf;
    bit    o_overlap;
    word_t o_rdata;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        kv10_mem_responder_if bus ();
        assign bus.address    = t_addr[g];
        assign bus.write_data = t_wdata[g];
        assign bus.read       = t_rd[g];
        assign bus.write      = t_wr[g];
        assign t_rdata[g]     = bus.read_data;
        assign t_rack[g]      = bus.read_ack;
        assign t_wack[g]      = bus.write_ack;
        assign t_pf[g]        = bus.page_fail;
        kv10_mem_responder #(.MEM_WORDS(MEMW), .LATENCY(LAT)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
    endfunction

    function automatic int key(input int d, input addr_t a);
        return d * MEMW + int'(a);
    endfunction

    function automatic word_t rnd_word();
        return word_t'({$urandom(), $urandom()});
    endfunction

    task automatic tally(input int d);
        int n;
        n = int'(t_rack[d]) + int'(t_wack[d]) + int'(t_pf[d]);
        o_rack += int'(t_rack[d]);
        o_wack += int'(t_wack[d]);
        o_pf   += int'(t_pf[d]);
        if (n > 1) o_overlap = 1'b1;
    endtask

    // Drive one request, record edges from E0 to the first pulse, hold, drop, keep watching.
    task automatic run_txn(input int d, input logic rd, input logic wr, input addr_t a,
                           input word_t wd, input int hold, input int post, input bit scramble);
        bit found;
        int k;
        o_lat = -1; o_rack = 0; o_wack = 0; o_pf = 0; o_overlap = 1'b0; o_rdata = '0;
        t_addr[d] = a; t_wdata[d] = wd; t_rd[d] = rd; t_wr[d] = wr;
        found = 1'b0;
        k = 0;
        while (!found && k < 40) begin
            @(posedge clk); #1;
            k++;
            if ((t_rack[d] | t_wack[d] | t_pf[d]) == 1'b1) begin
                found   = 1'b1;
                o_lat   = k - 1;
                o_rdata = t_rdata[d];
            end
            tally(d);
            if (k == 1 && scramble) begin
                t_addr[d]  = addr_t'($urandom());
                t_wdata[d] = rnd_word();
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            tally(d);
        end
        t_rd[d] = 1'b0; t_wr[d] = 1'b0;
        for (int i = 0; i < post; i++) begin
            @(posedge clk); #1;
            tally(d);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if ({t_rack[d], t_wack[d], t_pf[d]} !== 3'b000 || t_rdata[d] !== '0) begin
                errors++;
                $display("FAIL reset dut%0d: rack/wack/pf=%b%b%b read_data=%o, want 000 and 0",
                         d, t_rack[d], t_wack[d], t_pf[d], t_rdata[d]);
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        word_t v;
        v = 36'o123456701234;
        run_txn(0, 1'b0, 1'b1, 18'o100, v, 0, 1, 1'b0);
        checks++;
        if (o_lat !== 3 || o_wack !== 1 || o_rack !== 0 || o_pf !== 0 || o_overlap) begin
            errors++;
            $display("FAIL write_ack: lat=%0d wack=%0d rack=%0d pf=%0d, want lat=3 wack=1 rack=0 pf=0",
                     o_lat, o_wack, o_rack, o_pf);
        end
        mem_m[key(0, 18'o100)] = v;
        run_txn(0, 1'b1, 1'b0, 18'o100, '0, 0, 1, 1'b0);
        checks++;
        if (o_lat !== 3 || o_rack !== 1 || o_wack !== 0 || o_pf !== 0) begin
            errors++;
            $display("FAIL read_ack: lat=%0d rack=%0d wack=%0d pf=%0d, want lat=3 rack=1 wack=0 pf=0",
                     o_lat, o_rack, o_wack, o_pf);
        end
        last_rd[0] = v;
        checks++;
        if (o_rdata !== v || t_rdata[0] !== v) begin
            errors++;
            $display("FAIL read_data: at ack %o held %o, want %o", o_rdata, t_rdata[0], v);
        end
    endtask

    task automatic test_out_of_range();
        run_txn(0, 1'b1, 1'b0, 18'o10000, '0, 0, 1, 1'b0);
        checks++;
        if (o_lat !== 3 || o_pf !== 1 || o_rack !== 0 || o_wack !== 0) begin
            errors++;
            $display("FAIL oor_read: lat=%0d pf=%0d rack=%0d wack=%0d, want lat=3 pf=1 rack=0 wack=0",
                     o_lat, o_pf, o_rack, o_wack);
        end
        checks++;
        if (o_rdata !== last_rd[0] || t_rdata[0] !== last_rd[0]) begin
            errors++;
            $display("FAIL oor_read_data: %o/%o, want %o", o_rdata, t_rdata[0], last_rd[0]);
        end
        // Aliases 0o100 in the low bits; must fault and leave 0o100 alone.
        run_txn(0, 1'b0, 1'b1, 18'o10100, ~mem_m[key(0, 18'o100)], 0, 1, 1'b0);
        checks++;
        if (o_pf !== 1 || o_wack !== 0 || o_rack !== 0) begin
            errors++;
            $display("FAIL oor_write: pf=%0d wack=%0d rack=%0d, want pf=1 wack=0 rack=0",
                     o_pf, o_wack, o_rack);
        end
        run_txn(0, 1'b1, 1'b0, 18'o100, '0, 0, 1, 1'b0);
        last_rd[0] = mem_m[key(0, 18'o100)];
        checks++;
        if (o_rack !== 1 || o_rdata !== last_rd[0]) begin
            errors++;
            $display("FAIL oor_alias: rack=%0d data=%o, want rack=1 data=%o", o_rack, o_rdata, last_rd[0]);
        end
    endtask

    task automatic test_illegal();
        word_t w1;
        w1 = rnd_word();
        run_txn(0, 1'b0, 1'b1, 18'o5, w1, 0, 1, 1'b0);
        mem_m[key(0, 18'o5)] = w1;
        run_txn(0, 1'b1, 1'b1, 18'o5, ~w1, 0, 1, 1'b0);
        checks++;
        if (o_lat !== 3 || o_pf !== 1 || o_rack !== 0 || o_wack !== 0 || t_rdata[0] !== last_rd[0]) begin
            errors++;
            $display("FAIL illegal: lat=%0d pf=%0d rack=%0d wack=%0d data=%o, want lat=3 pf=1 rack=0 wack=0 data=%o",
                     o_lat, o_pf, o_rack, o_wack, t_rdata[0], last_rd[0]);
        end
        run_txn(0, 1'b1, 1'b0, 18'o5, '0, 0, 1, 1'b0);
        last_rd[0] = w1;
        checks++;
        if (o_rack !== 1 || o_rdata !== w1) begin
            errors++;
            $display("FAIL illegal_readback: rack=%0d data=%o, want rack=1 data=%o", o_rack, o_rdata, w1);
        end
    endtask

    task automatic test_held();
        run_txn(0, 1'b1, 1'b0, 18'o100, '0, 10, 1, 1'b0);
        last_rd[0] = mem_m[key(0, 18'o100)];
        checks++;
        if (o_lat !== 3 || o_rack !== 1 || o_wack !== 0 || o_pf !== 0 || t_rdata[0] !== last_rd[0]) begin
            errors++;
            $display("FAIL held: lat=%0d rack=%0d wack=%0d pf=%0d data=%o, want lat=3 single rack data=%o",
                     o_lat, o_rack, o_wack, o_pf, t_rdata[0], last_rd[0]);
        end
        // Issued one edge after the drop was sampled.
        run_txn(0, 1'b1, 1'b0, 18'o5, '0, 0, 1, 1'b0);
        last_rd[0] = mem_m[key(0, 18'o5)];
        checks++;
        if (o_lat !== 3 || o_rack !== 1 || o_rdata !== last_rd[0]) begin
            errors++;
            $display("FAIL held_next: lat=%0d rack=%0d data=%o, want lat=3 rack=1 data=%o",
                     o_lat, o_rack, o_rdata, last_rd[0]);
        end
    endtask

    task automatic test_reset_mid_write();
        int n;
        run_txn(0, 1'b0, 1'b1, 18'o200, '0, 0, 1, 1'b0);
        mem_m[key(0, 18'o200)] = '0;
        t_addr[0] = 18'o200; t_wdata[0] = rnd_word() | word_t'(1); t_wr[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0; t_wr[0] = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < NDUT; d++) last_rd[d] = '0;
        checks++;
        if ({t_rack[0], t_wack[0], t_pf[0]} !== 3'b000 || t_rdata[0] !== '0) begin
            errors++;
            $display("FAIL reset_mid_write: rack/wack/pf=%b%b%b data=%o, want 000 and 0",
                     t_rack[0], t_wack[0], t_pf[0], t_rdata[0]);
        end
        reset = 1'b1;
        n = 0;
        repeat (4) begin
            @(posedge clk); #1;
            n += int'(t_rack[0]) + int'(t_wack[0]) + int'(t_pf[0]);
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL reset_mid_write_quiet: pulses=%0d, want 0", n);
        end
        run_txn(0, 1'b1, 1'b0, 18'o200, '0, 0, 1, 1'b0);
        checks++;
        if (o_lat !== 3 || o_rack !== 1 || o_rdata !== '0) begin
            errors++;
            $display("FAIL reset_mid_write_readback: lat=%0d rack=%0d data=%o, want lat=3 rack=1 data=0",
                     o_lat, o_rack, o_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        int n;
        t_addr[0] = 18'o100; t_rd[0] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b0; t_rd[0] = 1'b0;
        n = 0;
        @(posedge clk); #1;
        n += int'(t_rack[0]) + int'(t_wack[0]) + int'(t_pf[0]);
        for (int d = 0; d < NDUT; d++) last_rd[d] = '0;
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            n += int'(t_rack[0]) + int'(t_wack[0]) + int'(t_pf[0]);
        end
        checks++;
        if (n !== 0 || t_rdata[0] !== '0) begin
            errors++;
            $display("FAIL reset_mid_read: pulses=%0d data=%o, want 0 pulses data=0", n, t_rdata[0]);
        end
    endtask

    task automatic test_latency_sweep();
        addr_t a;
        word_t v;
        for (int d = 1; d < NDUT; d++) begin
            a = addr_t'($urandom_range(0, MEMW - 1));
            v = rnd_word();
            run_txn(d, 1'b0, 1'b1, a, v, 0, 1, 1'b0);
            mem_m[key(d, a)] = v;
            checks++;
            if (o_lat !== lat_of(d) + 1 || o_wack !== 1 || o_rack !== 0 || o_pf !== 0 || o_overlap) begin
                errors++;
                $display("FAIL sweep_write dut%0d: lat=%0d wack=%0d rack=%0d pf=%0d, want lat=%0d wack=1",
                         d, o_lat, o_wack, o_rack, o_pf, lat_of(d) + 1);
            end
            for (int r = 0; r < 2; r++) begin
                run_txn(d, 1'b1, 1'b0, a, '0, 0, 1, 1'b0);
                last_rd[d] = v;
                checks++;
                if (o_lat !== lat_of(d) + 1 || o_rack !== 1 || o_wack !== 0 || o_pf !== 0 ||
                    o_rdata !== v || o_overlap) begin
                    errors++;
                    $display("FAIL sweep_read dut%0d #%0d: lat=%0d rack=%0d data=%o, want lat=%0d rack=1 data=%o",
                             d, r, o_lat, o_rack, o_rdata, lat_of(d) + 1, v);
                end
            end
        end
    endtask

    task automatic test_random();
        addr_t a;
        word_t wd, exp_rd;
        logic  rd, wr;
        bit    fault, scr;
        int    d, op;
        for (int dd = 0; dd < NDUT; dd++) begin
            for (int i = 0; i < 8; i++) begin
                wd = rnd_word();
                run_txn(dd, 1'b0, 1'b1, addr_t'(12'o300 + i), wd, 0, 1, 1'b0);
                mem_m[key(dd, addr_t'(12'o300 + i))] = wd;
            end
        end
        for (int it = 0; it < 60; it++) begin
            d  = int'($urandom_range(0, NDUT - 1));
            op = int'($urandom_range(0, 9));
            rd = (op <= 4 || op == 9);
            wr = (op >= 5);
            a  = addr_t'(12'o300 + $urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) a = a | addr_t'($urandom_range(1, 63) << 12);
            wd  = rnd_word();
            scr = ($urandom_range(0, 1) == 1);
            fault = (int'(a) >= MEMW) || (rd && wr);
            run_txn(d, rd, wr, a, wd, int'($urandom_range(0, 2)), 1, scr);
            if (!fault && rd) last_rd[d] = mem_m[key(d, a)];
            if (!fault && wr) mem_m[key(d, a)] = wd;
            exp_rd = last_rd[d];
            checks++;
            if (o_lat !== lat_of(d) + 1 || o_pf !== int'(fault) || o_rack !== int'(!fault && rd) ||
                o_wack !== int'(!fault && wr) || o_overlap) begin
                errors++;
                $display("FAIL random #%0d dut%0d rd=%b wr=%b a=%o: lat=%0d rack=%0d wack=%0d pf=%0d, want lat=%0d rack=%0d wack=%0d pf=%0d",
                         it, d, rd, wr, a, o_lat, o_rack, o_wack, o_pf, lat_of(d) + 1,
                         int'(!fault && rd), int'(!fault && wr), int'(fault));
            end
            checks++;
            if (o_rdata !== exp_rd || t_rdata[d] !== exp_rd) begin
                errors++;
                $display("FAIL random_data #%0d dut%0d: at pulse %o held %o, want %o",
                         it, d, o_rdata, t_rdata[d], exp_rd);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            t_addr[i]  = '0;
            t_wdata[i] = '0;
            last_rd[i] = '0;
        end
        t_rd  = '0;
        t_wr  = '0;
        reset = 1'b0;
        test_reset();
        test_write_read();
        test_out_of_range();
        test_illegal();
        test_held();
        test_reset_mid_write();
        test_reset_mid_read();
        test_latency_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
